// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned AW_DEF = 16;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_wait_ctr.sv
// Busy-cycle counter for the access watchdog: load to 1 on issue, increment while waiting.
module mem_access_ctrl_wait_ctr
  import mem_access_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count register; load has priority over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(1);
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues one memory access per load/store, stalls the
// pipeline until completion, and aborts accesses that exceed TIMEOUT busy cycles.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned ALIGN_CHK = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_m,
  input  logic          MemRead_m,
  input  logic          MemWrite_m,
  input  logic [AW-1:0] addr_m,
  input  logic [DW-1:0] wdata_m,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_o,
  output logic [DW-1:0] memResult_m,
  output logic          err_o
);

  state_e           state_q, state_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             cnt_load, cnt_inc;
  logic [CNT_W-1:0] wait_cnt;
  logic             acc, mis, timed_out;

  assign acc       = valid_m & (MemRead_m | MemWrite_m);
  assign mis       = (ALIGN_CHK != 0) & addr_m[0];
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT));

  mem_access_ctrl_wait_ctr u_wait_ctr (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .inc_i  (cnt_inc),
    .cnt_o  (wait_cnt)
  );

  // State and last-result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and combinational memory/pipeline outputs; everything quiet while in reset.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    stall_o     = 1'b0;
    err_o       = 1'b0;
    memResult_m = rdata_q;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            if (mis) begin
              err_o = 1'b1;
            end else begin
              mem_en    = 1'b1;
              mem_wr    = MemWrite_m;
              mem_addr  = addr_m;
              mem_wdata = wdata_m;
              if (mem_done) begin
                memResult_m = mem_rdata;
                rdata_d     = mem_rdata;
              end else begin
                stall_o  = 1'b1;
                cnt_load = 1'b1;
                state_d  = ST_BUSY;
              end
            end
          end
        end
        ST_BUSY: begin
          // Completion wins over a simultaneous timeout.
          if (mem_done) begin
            memResult_m = mem_rdata;
            rdata_d     = mem_rdata;
            state_d     = ST_IDLE;
          end else if (timed_out) begin
            err_o       = 1'b1;
            memResult_m = '0;
            rdata_d     = '0;
            state_d     = ST_IDLE;
          end else begin
            stall_o = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl using a transaction-level expectation model.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m, MemRead_m, MemWrite_m;
  logic [15:0] addr_m, wdata_m;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        stall_o;
  logic [15:0] memResult_m;
  logic        err_o;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] last   = 16'h0;
  int          stall_cnt;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DW(16), .AW(16), .TIMEOUT(TO), .ALIGN_CHK(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_m     (valid_m),
    .MemRead_m   (MemRead_m),
    .MemWrite_m  (MemWrite_m),
    .addr_m      (addr_m),
    .wdata_m     (wdata_m),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_done    (mem_done),
    .mem_rdata   (mem_rdata),
    .stall_o     (stall_o),
    .memResult_m (memResult_m),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    valid_m = 1'b0; MemRead_m = 1'b0; MemWrite_m = 1'b0;
    addr_m = 16'(urand()); wdata_m = 16'(urand());
    mem_done = 1'b0; mem_rdata = 16'(urand());
  endtask

  function automatic int unsigned urand();
    return $urandom;
  endfunction

  // One idle cycle, optionally with a stray completion pulse that must be ignored.
  task automatic idle_cycle(input bit stray_done);
    drive_idle();
    mem_done = stray_done;
    @(negedge clk);
    chk("idle_en",    16'(mem_en),  16'h0);
    chk("idle_stall", 16'(stall_o), 16'h0);
    chk("idle_err",   16'(err_o),   16'h0);
    chk("idle_res",   memResult_m,  last);
    @(posedge clk); #1;
  endtask

  // One load/store held in EX/MEM until released. lat = cycle (from issue) on which
  // memory completes; lat > TO means memory never answers.
  task automatic access(input bit wr, input bit rd, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [15:0] rdv, input int lat);
    bit mis;
    int endk;
    bit exp_st, exp_er;
    logic [15:0] exp_res;
    mis  = addr[0];
    endk = mis ? 0 : ((lat <= int'(TO)) ? lat : int'(TO));
    stall_cnt = 0;
    for (int k = 0; k <= endk; k++) begin
      valid_m = 1'b1; MemRead_m = rd; MemWrite_m = wr; addr_m = addr; wdata_m = wd;
      mem_done  = !mis && (k == lat);
      mem_rdata = (k == lat) ? rdv : 16'(urand());
      @(negedge clk);
      exp_st  = !mis && (k < endk);
      exp_er  = mis || ((lat > int'(TO)) && (k == endk));
      exp_res = last;
      if (!mis && k == endk) exp_res = (lat <= int'(TO)) ? rdv : 16'h0;
      if (stall_o) stall_cnt++;
      chk("mem_en",  16'(mem_en),  16'(!mis && k == 0));
      chk("stall",   16'(stall_o), 16'(exp_st));
      chk("err",     16'(err_o),   16'(exp_er));
      chk("result",  memResult_m,  exp_res);
      if (!mis && k == 0) begin
        chk("mem_wr",    16'(mem_wr), 16'(wr));
        chk("mem_addr",  mem_addr,    addr);
        chk("mem_wdata", mem_wdata,   wd);
      end
      @(posedge clk); #1;
    end
    if (!mis) last = (lat <= int'(TO)) ? rdv : 16'h0;
    drive_idle();
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    // Reset state
    @(posedge clk); @(negedge clk);
    chk("rst_en",    16'(mem_en),  16'h0);
    chk("rst_stall", 16'(stall_o), 16'h0);
    chk("rst_err",   16'(err_o),   16'h0);
    chk("rst_res",   memResult_m,  16'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero-wait load
    access(1'b0, 1'b1, 16'h0010, 16'h0, 16'hBEEF, 0);
    chk("zw_stall_cycles", 16'(stall_cnt), 16'd0);
    idle_cycle(1'b0);

    // Three-cycle load
    access(1'b0, 1'b1, 16'h0020, 16'h0, 16'h1234, 3);
    chk("l3_stall_cycles", 16'(stall_cnt), 16'd3);
    idle_cycle(1'b1);

    // Store, and read+write together treated as store
    access(1'b1, 1'b0, 16'h0042, 16'hA5A5, 16'h5555, 2);
    access(1'b1, 1'b1, 16'h0044, 16'h3C3C, 16'h6666, 1);

    // Misaligned
    access(1'b0, 1'b1, 16'h0003, 16'h0, 16'h7777, 1);
    idle_cycle(1'b0);

    // Timeout, then race (completion on the timeout cycle)
    access(1'b0, 1'b1, 16'h0030, 16'h0, 16'h9999, 99);
    chk("to_stall_cycles", 16'(stall_cnt), 16'(TO));
    access(1'b0, 1'b1, 16'h0032, 16'h0, 16'hCAFE, int'(TO));

    // Back-to-back loads: second issue in the cycle right after the first completes
    access(1'b0, 1'b1, 16'h0050, 16'h0, 16'h1111, 2);
    access(1'b0, 1'b1, 16'h0052, 16'h0, 16'h2222, 1);
    idle_cycle(1'b0);

    // Reset mid-BUSY at cycle 3
    for (int k = 0; k < 3; k++) begin
      valid_m = 1'b1; MemRead_m = 1'b1; MemWrite_m = 1'b0; addr_m = 16'h0060;
      mem_done = 1'b0;
      @(negedge clk);
      chk("prerst_stall", 16'(stall_o), 16'h1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("midrst_stall", 16'(stall_o), 16'h0);
    chk("midrst_err",   16'(err_o),   16'h0);
    chk("midrst_en",    16'(mem_en),  16'h0);
    chk("midrst_res",   memResult_m,  16'h0);
    last = 16'h0;
    drive_idle();
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    idle_cycle(1'b0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      bit          wr, rd;
      logic [15:0] a;
      int          gap;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = 16'(urand());
      if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
      access(wr, rd, a, 16'(urand()), 16'(urand()), int'($urandom_range(0, 6)));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
